// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC volume sequencer.
// The mute states are only reachable when DAC_SOFT_MUTE_EN is defined.
package dac_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    RAMP_DOWN = 3'd2,
    MUTING    = 3'd3,
    MUTED     = 3'd4
  } dac_state_e;

  function automatic int pwm_counter(input int sys_freq_hz, input int pwm_freq);
    return sys_freq_hz / pwm_freq;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val > 32'sd0) ? $clog2(max_val + 32'sd1) : 32'sd1;
  endfunction

endpackage

// File: rtl/dac_period_tick.sv
// PWM period tick: a 0..PWM_COUNTER counter with a one-cycle tick on the wrap value.
module dac_period_tick
  import dac_pkg::*;
#(
  parameter int SYS_FREQ_HZ = 32'd150_000_000,
  parameter int PWM_FREQ    = 32'd100_000
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int PWM_COUNTER = pwm_counter(SYS_FREQ_HZ, PWM_FREQ);
  localparam int CW          = cnt_width(PWM_COUNTER);
  localparam logic [CW-1:0] CNT_LAST = CW'(PWM_COUNTER);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          tick_r;

  // Next counter value, wrapping after the last PWM count
  always_comb begin
    if (cnt_r == CNT_LAST) begin
      cnt_next_s = '0;
    end else begin
      cnt_next_s = cnt_r + CW'(1);
    end
  end

  // Tick is registered so it is high exactly while cnt_r holds the wrap value
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_next_s;
      tick_r <= (cnt_next_s == CNT_LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/dac_volume_sequencer.sv
// Ramps the PWM DAC duty value toward requested volumes, one step per period tick.
// Optional soft mute (mute port, MUTING/MUTED states) is enabled by DAC_SOFT_MUTE_EN.
module dac_volume_sequencer
  import dac_pkg::*;
#(
  parameter int SYS_FREQ_HZ = 32'd150_000_000,
  parameter int PWM_FREQ    = 32'd100_000,
  parameter int DATA_WIDTH  = 32'd8,
  parameter int STEP        = 32'd1,
  parameter int RAMP_DIV    = 32'd1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] target_vol,
  input  logic                  target_valid,
  output logic                  target_ready,
`ifdef DAC_SOFT_MUTE_EN
  input  logic                  mute,
`endif
  output logic [DATA_WIDTH-1:0] volumen_control,
  output logic                  busy,
  output logic                  ramp_done,
  output logic                  muted
);

  localparam int W     = DATA_WIDTH;
  localparam int DIV_W = cnt_width(RAMP_DIV - 32'sd1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 32'sd1);
  localparam logic [W:0]       STEP_X   = (W+1)'(STEP);
  localparam logic [W-1:0]     STEP_N   = W'(STEP);

  dac_state_e       state_r, state_next_s;
  logic [W-1:0]     vol_r, vol_next_s;
  logic [W-1:0]     restore_r, restore_next_s;
  logic [DIV_W-1:0] div_r, div_next_s;
  logic             done_r, done_next_s;
  logic             busy_r, muted_r;

  logic             tick_s;
  logic             mute_req_s;
  logic             ready_s, accept_s;
  logic             ramping_s, abort_s, step_s, advance_s, reached_s;
  logic [W-1:0]     ramp_tgt_s, stepped_s;
  logic [W:0]       sum_s, floor_s;

  dac_period_tick #(
    .SYS_FREQ_HZ (SYS_FREQ_HZ),
    .PWM_FREQ    (PWM_FREQ)
  ) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .tick   (tick_s)
  );

`ifdef DAC_SOFT_MUTE_EN
  dac_state_e resume_state_s;

  assign mute_req_s = mute;
  assign ready_s    = (state_r == IDLE) && !mute;
  // A ramp is abandoned when mute disagrees with the current direction of travel
  assign abort_s    = ramping_s && (mute != (state_r == MUTING));

  // Where to go when mute is released: back toward the restore level
  always_comb begin
    if (vol_r < restore_r) begin
      resume_state_s = RAMP_UP;
    end else if (vol_r > restore_r) begin
      resume_state_s = RAMP_DOWN;
    end else begin
      resume_state_s = IDLE;
    end
  end
`else
  assign mute_req_s = 1'b0;
  assign ready_s    = (state_r == IDLE);
  assign abort_s    = 1'b0;
`endif

  assign accept_s   = target_valid && ready_s;
  assign ramping_s  = (state_r == RAMP_UP) || (state_r == RAMP_DOWN) || (state_r == MUTING);
  assign step_s     = tick_s && (div_r == DIV_LAST);
  assign advance_s  = ramping_s && step_s && !abort_s;
  assign ramp_tgt_s = (state_r == MUTING) ? {W{1'b0}} : restore_r;
  assign reached_s  = (stepped_s == ramp_tgt_s);

  // Saturating one-step move toward the ramp target, computed one bit wider
  always_comb begin
    sum_s     = {1'b0, vol_r} + STEP_X;
    floor_s   = {1'b0, ramp_tgt_s} + STEP_X;
    stepped_s = vol_r;
    case (state_r)
      RAMP_UP: begin
        if (sum_s >= {1'b0, ramp_tgt_s}) begin
          stepped_s = ramp_tgt_s;
        end else begin
          stepped_s = sum_s[W-1:0];
        end
      end
      RAMP_DOWN, MUTING: begin
        if ({1'b0, vol_r} <= floor_s) begin
          stepped_s = ramp_tgt_s;
        end else begin
          stepped_s = vol_r - STEP_N;
        end
      end
      default: stepped_s = vol_r;
    endcase
  end

  // Next-state logic; mute takes priority over requests and ramps
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (mute_req_s) begin
          state_next_s = MUTING;
        end else if (accept_s && (target_vol > vol_r)) begin
          state_next_s = RAMP_UP;
        end else if (accept_s && (target_vol < vol_r)) begin
          state_next_s = RAMP_DOWN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RAMP_UP, RAMP_DOWN: begin
        if (mute_req_s) begin
          state_next_s = MUTING;
        end else if (advance_s && reached_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
`ifdef DAC_SOFT_MUTE_EN
      MUTING: begin
        if (!mute) begin
          state_next_s = resume_state_s;
        end else if (advance_s && reached_s) begin
          state_next_s = MUTED;
        end else begin
          state_next_s = MUTING;
        end
      end
      MUTED: begin
        if (!mute) begin
          state_next_s = resume_state_s;
        end else begin
          state_next_s = MUTED;
        end
      end
`endif
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath next values; any state change restarts the step divider
  always_comb begin
    if (advance_s) begin
      vol_next_s = stepped_s;
    end else begin
      vol_next_s = vol_r;
    end
    if (accept_s) begin
      restore_next_s = target_vol;
    end else begin
      restore_next_s = restore_r;
    end
    if (accept_s || (state_next_s != state_r)) begin
      div_next_s = '0;
    end else if (ramping_s && tick_s) begin
      div_next_s = (div_r == DIV_LAST) ? {DIV_W{1'b0}} : div_r + DIV_W'(1);
    end else begin
      div_next_s = div_r;
    end
    done_next_s = (state_next_s == IDLE) && ((state_r != IDLE) || accept_s);
  end

  // State register
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      vol_r     <= '0;
      restore_r <= '0;
      div_r     <= '0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      muted_r   <= 1'b0;
    end else begin
      vol_r     <= vol_next_s;
      restore_r <= restore_next_s;
      div_r     <= div_next_s;
      done_r    <= done_next_s;
      busy_r    <= (state_next_s != IDLE);
      muted_r   <= (state_next_s == MUTED);
    end
  end

  assign target_ready    = ready_s;
  assign volumen_control = vol_r;
  assign busy            = busy_r;
  assign ramp_done       = done_r;
  assign muted           = muted_r;

endmodule

// File: tb/tb_dac_volume_sequencer.sv
// Directed bench for dac_volume_sequencer (11-cycle PWM period, STEP 4, RAMP_DIV 1).
// Soft-mute steps are included when DAC_SOFT_MUTE_EN is defined.
module tb_dac_volume_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] target_vol;
  logic       target_valid;
  logic       target_ready;
`ifdef DAC_SOFT_MUTE_EN
  logic       mute;
`endif
  logic [7:0] volumen_control;
  logic       busy;
  logic       ramp_done;
  logic       muted;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int n;

  dac_volume_sequencer #(
    .SYS_FREQ_HZ (1000),
    .PWM_FREQ    (100),
    .DATA_WIDTH  (8),
    .STEP        (4),
    .RAMP_DIV    (1)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .target_vol      (target_vol),
    .target_valid    (target_valid),
    .target_ready    (target_ready),
`ifdef DAC_SOFT_MUTE_EN
    .mute            (mute),
`endif
    .volumen_control (volumen_control),
    .busy            (busy),
    .ramp_done       (ramp_done),
    .muted           (muted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until volumen_control changes (bounded); cyc returns cycles taken
  task automatic wait_change(input string tag, output int cyc);
    logic [7:0] prev;
    prev = volumen_control;
    cyc  = 0;
    while (cyc < 40) begin
      step();
      cyc++;
      if (volumen_control !== prev) break;
    end
    check({tag, "_moved"}, 32'(volumen_control !== prev), 32'd1);
  endtask

  initial begin
    resetn       = 1'b1;
    target_vol   = 8'd0;
    target_valid = 1'b0;
`ifdef DAC_SOFT_MUTE_EN
    mute         = 1'b0;
`endif
    repeat (3) step();
    check("rst_vol",   32'(volumen_control), 32'd0);
    check("rst_busy",  32'(busy),            32'd0);
    check("rst_done",  32'(ramp_done),       32'd0);
    check("rst_muted", 32'(muted),           32'd0);
    check("rst_ready", 32'(target_ready),    32'd1);
    resetn = 1'b0;

    // ramp up 0 -> 10
    target_vol   = 8'd10;
    target_valid = 1'b1;
    step();
    target_valid = 1'b0;
    check("up_acc_ready", 32'(target_ready), 32'd0);
    check("up_acc_busy",  32'(busy),         32'd1);
    check("up_acc_vol",   32'(volumen_control), 32'd0);
    wait_change("up1", n);
    check("up1_vol",   32'(volumen_control), 32'd4);
    check("up1_done",  32'(ramp_done),       32'd0);
    check("up1_ready", 32'(target_ready),    32'd0);
    wait_change("up2", n);
    check("up2_period", 32'(n), 32'd11);
    check("up2_vol",    32'(volumen_control), 32'd8);
    check("up2_ready",  32'(target_ready),    32'd0);
    wait_change("up3", n);
    check("up3_period", 32'(n), 32'd11);
    check("up3_vol",    32'(volumen_control), 32'd10);
    check("up3_done",   32'(ramp_done),       32'd1);
    check("up3_busy",   32'(busy),            32'd0);
    check("up3_ready",  32'(target_ready),    32'd1);
    step();
    check("up3_done_1cyc", 32'(ramp_done), 32'd0);

    // equal request: no ramp, done one cycle later
    target_vol   = 8'd10;
    target_valid = 1'b1;
    step();
    target_valid = 1'b0;
    check("eq_done", 32'(ramp_done),       32'd1);
    check("eq_busy", 32'(busy),            32'd0);
    check("eq_vol",  32'(volumen_control), 32'd10);
    step();
    check("eq_done_1cyc", 32'(ramp_done), 32'd0);
    check("eq_busy2",     32'(busy),      32'd0);

`ifdef DAC_SOFT_MUTE_EN
    // soft mute from 10 and restore
    mute = 1'b1;
    #1;
    check("mute_ready", 32'(target_ready), 32'd0);
    wait_change("m1", n);
    check("m1_vol",   32'(volumen_control), 32'd6);
    check("m1_busy",  32'(busy),            32'd1);
    wait_change("m2", n);
    check("m2_vol",   32'(volumen_control), 32'd2);
    wait_change("m3", n);
    check("m3_period", 32'(n), 32'd11);
    check("m3_vol",   32'(volumen_control), 32'd0);
    check("m3_muted", 32'(muted),           32'd1);
    check("m3_done",  32'(ramp_done),       32'd0);
    step();
    mute = 1'b0;
    step();
    check("unmute_muted", 32'(muted), 32'd0);
    check("unmute_busy",  32'(busy),  32'd1);
    wait_change("u1", n);
    check("u1_vol", 32'(volumen_control), 32'd4);
    wait_change("u2", n);
    check("u2_vol", 32'(volumen_control), 32'd8);
    wait_change("u3", n);
    check("u3_vol",  32'(volumen_control), 32'd10);
    check("u3_done", 32'(ramp_done),       32'd1);
    step();
    check("u3_done_1cyc", 32'(ramp_done), 32'd0);
`endif

    // ramp down 10 -> 0, no wrap
    target_vol   = 8'd0;
    target_valid = 1'b1;
    step();
    target_valid = 1'b0;
    wait_change("dn1", n);
    check("dn1_vol", 32'(volumen_control), 32'd6);
    wait_change("dn2", n);
    check("dn2_vol", 32'(volumen_control), 32'd2);
    wait_change("dn3", n);
    check("dn3_vol",  32'(volumen_control), 32'd0);
    check("dn3_done", 32'(ramp_done),       32'd1);
    repeat (15) step();
    check("dn_floor_vol",  32'(volumen_control), 32'd0);
    check("dn_floor_busy", 32'(busy),            32'd0);

    // long ramp to 250
    target_vol   = 8'd250;
    target_valid = 1'b1;
    step();
    target_valid = 1'b0;
    n = 0;
    while (n < 1000 && ramp_done !== 1'b1) begin
      step();
      n++;
    end
    check("r250_done", 32'(ramp_done),       32'd1);
    check("r250_vol",  32'(volumen_control), 32'd250);

    // 250 -> 255 saturates; second request held until done
    target_vol   = 8'd255;
    target_valid = 1'b1;
    step();
    check("sat_busy", 32'(busy), 32'd1);
    target_vol = 8'd0;
    check("sat_ready_hold", 32'(target_ready), 32'd0);
    wait_change("sat1", n);
    check("sat1_vol",   32'(volumen_control), 32'd254);
    check("sat1_ready", 32'(target_ready),    32'd0);
    wait_change("sat2", n);
    check("sat2_vol",   32'(volumen_control), 32'd255);
    check("sat2_done",  32'(ramp_done),       32'd1);
    check("sat2_ready", 32'(target_ready),    32'd1);
    step();
    target_valid = 1'b0;
    check("second_busy", 32'(busy),            32'd1);
    check("second_done", 32'(ramp_done),       32'd0);
    check("second_vol",  32'(volumen_control), 32'd255);
    wait_change("second1", n);
    check("second1_vol", 32'(volumen_control), 32'd251);
    resetn = 1'b1;
    #1;
    check("rst_mid_vol",  32'(volumen_control), 32'd0);
    check("rst_mid_busy", 32'(busy),            32'd0);
    step();
    resetn = 1'b0;

    // async reset while ramping at 8
    target_vol   = 8'd20;
    target_valid = 1'b1;
    step();
    target_valid = 1'b0;
    wait_change("ar1", n);
    check("ar1_vol", 32'(volumen_control), 32'd4);
    wait_change("ar2", n);
    check("ar2_vol",  32'(volumen_control), 32'd8);
    check("ar2_busy", 32'(busy),            32'd1);
    #2;
    resetn = 1'b1;
    #1;
    check("ar_vol",   32'(volumen_control), 32'd0);
    check("ar_busy",  32'(busy),            32'd0);
    check("ar_done",  32'(ramp_done),       32'd0);
    check("ar_ready", 32'(target_ready),    32'd1);
    step();
    resetn = 1'b0;
    step();
    check("ar_after_vol", 32'(volumen_control), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dac_volume_sequencer.md
DAC_VOLUME_SEQUENCER -- requirements
Module: dac_volume_sequencer

Interface
REQ-001 SHALL have parameter SYS_FREQ_HZ, default 150000000: system clock frequency in Hz.
REQ-002 SHALL have parameter PWM_FREQ, default 100000: PWM frequency in Hz; PWM_COUNTER = SYS_FREQ_HZ/PWM_FREQ.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: width of volume values.
REQ-004 SHALL have parameter STEP, default 1: volume change applied per ramp step.
REQ-005 SHALL have parameter RAMP_DIV, default 1: number of PWM period ticks per ramp step (at least 1).
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port resetn, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port target_vol, input, DATA_WIDTH: requested volume.
REQ-009 SHALL have port target_valid, input, 1: request valid.
REQ-010 SHALL have port target_ready, output, 1: request can be accepted.
REQ-011 SHALL have port mute, input, 1: soft-mute level request (only with DAC_SOFT_MUTE_EN).
REQ-012 SHALL have port volumen_control, output, DATA_WIDTH: duty value driven to the PWM DAC.
REQ-013 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-014 SHALL have port ramp_done, output, 1: single-cycle pulse when a ramp reaches its target.
REQ-015 SHALL have port muted, output, 1: high in MUTED.

Function
REQ-016 SHALL generate a period tick from a 0..PWM_COUNTER counter, one cycle wide when counter==PWM_COUNTER, i.e. every PWM_COUNTER+1 cycles, aligned with the DAC PWM wrap.
REQ-017 SHALL drive target_ready = (state==IDLE) and not mute; a request is accepted on a cycle with target_valid and target_ready both high.
REQ-018 SHALL latch target_vol on accept as the restore level, reset the RAMP_DIV step counter, and go to RAMP_UP if target > volumen_control, to RAMP_DOWN if target < volumen_control, else stay IDLE and pulse ramp_done on the next cycle.
REQ-019 SHALL step only on a tick cycle where the step counter reaches RAMP_DIV-1:
  - RAMP_UP: cur = min(cur+STEP, target).
  - RAMP_DOWN: cur = max(cur-STEP, target).
REQ-020 SHALL compute ramp arithmetic at DATA_WIDTH+1 bits, saturated, with no wrap-around at 0 or at 2^DATA_WIDTH-1.
REQ-021 SHALL, on the step that makes cur equal the target, enter IDLE and assert ramp_done on that same cycle for exactly one cycle.
REQ-022 SHALL register volumen_control, changing only on tick cycles, so the value never changes mid-period.
REQ-023 SHALL hold target_ready low during a ramp; the requester keeps target_valid asserted until accepted.

Reset
REQ-024 SHALL, while resetn is high, asynchronously force: state IDLE, volumen_control 0, restore level 0, both counters 0, busy 0, ramp_done 0, muted 0.
REQ-025 SHALL let reset mid-ramp abort immediately to 0, with no ramp-down.

Configuration
REQ-026 SHALL, with DAC_SOFT_MUTE_EN defined, provide the mute port and the MUTING and MUTED states:
  - mute high in any state aborts the current ramp and enters MUTING, ramping toward 0 by STEP per step.
  - Reaching 0 enters MUTED, with muted=1.
  - mute falling in MUTING or MUTED enters RAMP_UP (or RAMP_DOWN) toward the restore level.
  - If already at the restore level, the block enters IDLE and pulses ramp_done.
REQ-027 SHALL, without DAC_SOFT_MUTE_EN, omit the mute port and both mute states, tie muted to 0, and drop the mute term from target_ready.

Structure
REQ-028 SHALL place in shared package dac_pkg: the state enumeration (IDLE, RAMP_UP, RAMP_DOWN, MUTING, MUTED) and the PWM_COUNTER derivation constant/function.
REQ-029 SHALL implement the period tick in sub-module dac_period_tick (parameters SYS_FREQ_HZ, PWM_FREQ; output tick).

Verification (SYS_FREQ_HZ=1000, PWM_FREQ=100 giving an 11-cycle period; DATA_WIDTH=8, STEP=4, RAMP_DIV=1)
REQ-030 SHALL cover: after reset, request 10 -> volumen_control 4, 8, 10 on three successive ticks; ramp_done one cycle at the third tick; target_ready low until then.
REQ-031 SHALL cover: at 10, request 10 -> no output change; ramp_done one cycle after accept; busy stays 0.
REQ-032 SHALL cover: at 10, request 0 -> 6, 2, 0 on successive ticks; never wraps below 0.
REQ-033 SHALL cover: at 250, request 255 -> 254, then 255 saturated; a second valid request presented during the ramp is accepted only after ramp_done.
REQ-034 SHALL cover (DAC_SOFT_MUTE_EN): at 10, assert mute -> 6, 2, 0 then muted=1; deassert -> 4, 8, 10 with ramp_done.
REQ-035 SHALL cover: assert resetn mid-ramp at 8 -> volumen_control 0 in the same cycle, asynchronously; busy 0.
